// File: rtl/pipe_fixed_point_to_float32.sv
// Pipelined signed fixed-point to IEEE-754 single-precision converter.
// One normalize step per stage, then optional round-half-up, then pack.
module pipe_fixed_point_to_float32 #(
    parameter int unsigned WII   = 8,
    parameter int unsigned WIF   = 8,
    parameter int unsigned ROUND = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WII+WIF-1:0] in,
    input  logic               i_valid,
    output logic [31:0]        out,
    output logic               o_valid
);

    localparam int unsigned W  = WII + WIF;
    localparam int unsigned L  = W + 3;
    localparam int unsigned EW = 10;
    localparam logic [EW-1:0] EXP_INIT = EW'(127 + W - 1 - WIF);

    // Stage 0 is the sign/magnitude capture, stages 1..W are normalize steps
    logic [W:0][W-1:0]  mag_q, mag_d;
    logic [W:0][EW-1:0] exp_q, exp_d;
    logic [W:0]         sgn_q, sgn_d;

    logic [22:0] rman_q, rman_d;
    logic [7:0]  rexp_q, rexp_d;
    logic        rsgn_q, rsgn_d;
    logic        rnz_q,  rnz_d;

    logic [31:0] out_q, out_d;
    logic [L-1:0] vld_q, vld_d;

    logic [24:0] top_c;
    logic        guard_c;
    logic [23:0] man_sum_c;

    // Magnitude capture and the chain of single-bit normalize steps
    always_comb begin
        mag_d = '0;
        exp_d = '0;
        sgn_d = '0;

        sgn_d[0] = in[W-1];
        mag_d[0] = in[W-1] ? W'(~in + W'(1)) : in;
        exp_d[0] = EXP_INIT;

        for (int unsigned j = 1; j <= W; j++) begin
            sgn_d[j] = sgn_q[j-1];
            if (!mag_q[j-1][W-1] && (|mag_q[j-1])) begin
                mag_d[j] = mag_q[j-1] << 1;
                exp_d[j] = exp_q[j-1] - EW'(1);
            end else begin
                mag_d[j] = mag_q[j-1];
                exp_d[j] = exp_q[j-1];
            end
        end
    end

    // Mantissa extraction and guard-bit rounding; top_c = {msb, mantissa, guard}
    always_comb begin
        top_c     = 25'({mag_q[W], 24'b0} >> (W - 1));
        guard_c   = (ROUND != 0) && top_c[0];
        man_sum_c = {1'b0, top_c[23:1]} + {23'b0, guard_c};
        rman_d    = man_sum_c[22:0];
        rexp_d    = 8'(exp_q[W] + EW'(man_sum_c[23]));
        rsgn_d    = sgn_q[W];
        rnz_d     = top_c[24];
    end

    // Final packing; a zero magnitude always yields +0
    always_comb begin
        out_d = rnz_q ? {rsgn_q, rexp_q, rman_q} : 32'h0;
        vld_d = {vld_q[L-2:0], i_valid};
    end

    // Pipeline registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q  <= '0;
            exp_q  <= '0;
            sgn_q  <= '0;
            rman_q <= '0;
            rexp_q <= '0;
            rsgn_q <= 1'b0;
            rnz_q  <= 1'b0;
            out_q  <= '0;
            vld_q  <= '0;
        end else begin
            mag_q  <= mag_d;
            exp_q  <= exp_d;
            sgn_q  <= sgn_d;
            rman_q <= rman_d;
            rexp_q <= rexp_d;
            rsgn_q <= rsgn_d;
            rnz_q  <= rnz_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
        end
    end

    assign out     = out_q;
    assign o_valid = vld_q[L-1];

endmodule
